// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared constants, state encoding and helpers for the RS(255,239) encoder controller
//
// Purpose: symbol width, code geometry, frame counter width, FSM state type.
// Ports:   none (package).
// Option:  RS_ENC_SHORTEN_EN uses clamp_k() to bound the programmable message length.

package rs_pkg;

  localparam int SYM_W = 8;
  localparam int N     = 255;
  localparam int K     = 239;
  localparam int NPAR  = N - K;   // must equal the depth of the external parity chain (16)
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } state_t;

  // Shortened-code length: 0 or anything above K falls back to the full message length.
  function automatic logic [CNT_W-1:0] clamp_k(input logic [CNT_W-1:0] k);
    if (k == '0 || k > CNT_W'(K)) begin
      return CNT_W'(K);
    end
    return k;
  endfunction

endpackage

// File: rtl/rs_enc_ctrl_if.sv
// rtl/rs_enc_ctrl_if.sv - symbol stream bundle between source, encoder controller and framer
//
// Purpose: groups the message input stream and the codeword output stream.
// Signals: in_valid/in_ready/in_data/in_sop  - message symbols into the encoder
//          out_valid/out_ready/out_data/out_sop/out_eop - codeword symbols out of the encoder
// Modports: master - environment side (drives message stream and out_ready)
//           slave  - encoder controller side

interface rs_enc_ctrl_if
  import rs_pkg::*;
#(
  parameter int SYM_W_P = SYM_W
);

  logic               in_valid;
  logic               in_ready;
  logic [SYM_W_P-1:0] in_data;
  logic               in_sop;

  logic               out_valid;
  logic               out_ready;
  logic [SYM_W_P-1:0] out_data;
  logic               out_sop;
  logic               out_eop;

  modport master (
    output in_valid, in_data, in_sop, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_data, in_sop, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop
  );

endinterface

// File: rtl/rs_frame_cnt.sv
// rtl/rs_frame_cnt.sv - frame symbol counter with enable, synchronous clear and terminal-count compare
//
// Purpose: counts accepted symbols within the message or parity phase.
// Ports:   clk, rst     - clock, synchronous active-high reset
//          en           - increment
//          clr          - synchronous clear to 0 (wins over en)
//          tc_val       - terminal count value
//          cnt          - current count
//          tc           - cnt == tc_val

module rs_frame_cnt
  import rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] tc_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == tc_val);

endmodule

// File: rtl/rs_enc_ctrl.sv
// rtl/rs_enc_ctrl.sv - frame sequencer for the 16-stage RS(255,239) parity LFSR chain
//
// Purpose: passes message symbols through while feeding the parity chain, then reads
//          out the 16 parity symbols by shifting the chain with zero feedback.
// Ports:   clk, rst   - clock, synchronous active-high reset
//          bus        - rs_enc_ctrl_if.slave: message stream in, codeword stream out
//          cfg_k      - shortened message length, sampled on accepted sop
//                       (only when RS_ENC_SHORTEN_EN is defined)
//          par_msb    - last-stage parity register of the chain (r_15)
//          fb_sym     - feedback symbol to the chain
//          lfsr_en    - chain shift enable
//          lfsr_clr   - chain synchronous clear
//          frm_err    - one-cycle pulse on framing error
// Option:  RS_ENC_SHORTEN_EN - programmable message length via cfg_k.

module rs_enc_ctrl
  import rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rs_enc_ctrl_if.slave     bus,
`ifdef RS_ENC_SHORTEN_EN
  input  logic [CNT_W-1:0] cfg_k,
`endif
  input  logic [SYM_W-1:0] par_msb,
  output logic [SYM_W-1:0] fb_sym,
  output logic             lfsr_en,
  output logic             lfsr_clr,
  output logic             frm_err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt, tc_val, start_k, k_eff;
  logic             tc, cnt_en, cnt_clr;
  logic             err_ev, frm_err_q;
  logic             start, restart_v;

  // Frame start is only taken when downstream can accept the sop symbol in the same cycle.
  assign start = (state_q == IDLE) && bus.in_valid && bus.in_sop && bus.out_ready;

  // A sop arriving mid-message aborts the current frame; the symbol is held upstream
  // and re-presented as the first symbol of the new frame once back in IDLE.
  assign restart_v = (state_q == MSG) && bus.in_valid && bus.in_sop && (cnt != '0);

`ifdef RS_ENC_SHORTEN_EN
  logic [CNT_W-1:0] k_q;

  assign start_k = clamp_k(cfg_k);

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= CNT_W'(K);
    end else if (start) begin
      k_q <= start_k;
    end
  end

  assign k_eff = k_q;
`else
  assign start_k = CNT_W'(K);
  assign k_eff   = CNT_W'(K);
`endif

  assign tc_val = (state_q == PAR) ? CNT_W'(NPAR - 1) : (k_eff - CNT_W'(1));

  rs_frame_cnt u_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .tc_val (tc_val),
    .cnt    (cnt),
    .tc     (tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frm_err_q <= err_ev;
    end
  end

  // Next-state and counter control; out_ready low freezes everything.
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    err_ev  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.out_ready) begin
          if (bus.in_sop) begin
            // A one-symbol message is complete on the sop itself.
            if (start_k == CNT_W'(1)) begin
              state_d = PAR;
              cnt_clr = 1'b1;
            end else begin
              state_d = MSG;
              cnt_en  = 1'b1;
            end
          end else begin
            err_ev = 1'b1;
          end
        end
      end
      MSG: begin
        if (bus.in_valid && bus.out_ready) begin
          if (restart_v) begin
            err_ev  = 1'b1;
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else if (tc) begin
            state_d = PAR;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      PAR: begin
        if (bus.out_ready) begin
          if (tc) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Output decode, combinational from state/cnt/inputs.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_sop   = 1'b0;
    bus.out_eop   = 1'b0;
    fb_sym        = '0;
    lfsr_en       = 1'b0;
    lfsr_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = bus.out_ready;
        lfsr_clr     = !start;
        if (start) begin
          bus.out_valid = 1'b1;
          bus.out_sop   = 1'b1;
          bus.out_data  = bus.in_data;
          fb_sym        = bus.in_data;   // chain is clear, so r_15 contributes nothing
          lfsr_en       = 1'b1;
        end
      end
      MSG: begin
        bus.in_ready  = bus.out_ready && !restart_v;
        bus.out_valid = bus.in_valid && !restart_v;
        bus.out_data  = bus.in_data;
        fb_sym        = bus.in_data ^ par_msb;
        lfsr_en       = bus.in_valid && bus.out_ready && !restart_v;
        lfsr_clr      = restart_v && bus.out_ready;
      end
      PAR: begin
        bus.out_valid = 1'b1;
        bus.out_data  = par_msb;
        bus.out_eop   = tc;
        lfsr_en       = bus.out_ready;   // fb_sym stays 0: chain shifts parity out
      end
      default: begin
        lfsr_clr = 1'b1;
      end
    endcase
  end

  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_rs_enc_ctrl.sv
// tb/tb_rs_enc_ctrl.sv - self-checking scoreboard bench for rs_enc_ctrl with a GF(2^8) parity chain model

module tb_rs_enc_ctrl;
  import rs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_enc_ctrl_if bus ();

  logic [SYM_W-1:0] par_msb, fb_sym;
  logic             lfsr_en, lfsr_clr, frm_err;
`ifdef RS_ENC_SHORTEN_EN
  logic [CNT_W-1:0] cfg_k;
`endif

  rs_enc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
`ifdef RS_ENC_SHORTEN_EN
    .cfg_k    (cfg_k),
`endif
    .par_msb  (par_msb),
    .fb_sym   (fb_sym),
    .lfsr_en  (lfsr_en),
    .lfsr_clr (lfsr_clr),
    .frm_err  (frm_err)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       par;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] g   [0:16];
  logic [7:0] msg [0:254];
  logic [7:0] r   [0:15];
  int         checks = 0;
  int         errors = 0;
  int         frm_err_cnt = 0;
  int         rdy_mode = 2;   // 0: always ready, 1: toggle, 2: held low
  bit         mon_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
    end
    return p;
  endfunction

  // g(x) = prod_{i=0..15} (x + alpha^i), g[j] is the coefficient of x^j
  task automatic build_gen();
    logic [7:0] a;
    a = 8'h01;
    for (int i = 0; i <= 16; i++) g[i] = 8'h00;
    g[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], a);
      g[0] = gf_mul(g[0], a);
      a = gf_mul(a, 8'h02);
    end
  endtask

  // External parity chain model driven by the DUT's fb_sym/lfsr_en/lfsr_clr
  always @(posedge clk) begin
    if (lfsr_clr) begin
      for (int i = 0; i < 16; i++) r[i] <= 8'h00;
    end else if (lfsr_en) begin
      r[0] <= gf_mul(g[0], fb_sym);
      for (int i = 1; i < 16; i++) r[i] <= r[i-1] ^ gf_mul(g[i], fb_sym);
    end
  end
  assign par_msb = r[15];

  // Golden codeword by polynomial long division of m(x)*x^16 by g(x)
  task automatic push_codeword(input int len);
    logic [7:0] d [0:254];
    logic [7:0] c;
    exp_t       e;
    for (int i = 0; i < len + 16; i++) d[i] = (i < len) ? msg[i] : 8'h00;
    for (int i = 0; i < len; i++) begin
      c = d[i];
      for (int j = 1; j <= 16; j++) d[i+j] = d[i+j] ^ gf_mul(c, g[16-j]);
    end
    for (int i = 0; i < len + 16; i++) begin
      e.d   = (i < len) ? msg[i] : d[i];
      e.sop = (i == 0);
      e.eop = (i == len + 15);
      e.par = (i >= len);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_prefix(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = msg[i]; e.sop = (i == 0); e.eop = 1'b0; e.par = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the posedge that accepted the last symbol.
  task automatic send_syms(input int len, input bit with_sop);
    int guard;
    bit ok;
    for (int i = 0; i < len; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = msg[i];
      bus.in_sop   = with_sop && (i == 0);
      guard = 0;
      ok    = 1'b0;
      do begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!ok && guard < 100);
      if (!ok) check_eq("in_accept_timeout", 32'(ok), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (frm_err) frm_err_cnt++;
      if (!bus.out_ready) check_eq("lfsr_en_hold", 32'(lfsr_en), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out_data", 32'(bus.out_data), 32'(mon_e.d));
          check_eq("out_sop",  32'(bus.out_sop),  32'(mon_e.sop));
          check_eq("out_eop",  32'(bus.out_eop),  32'(mon_e.eop));
          if (mon_e.par) check_eq("in_ready_par", 32'(bus.in_ready), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    build_gen();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_data  = 8'h00;
`ifdef RS_ENC_SHORTEN_EN
    cfg_k = 8'd0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: IDLE outputs with out_ready held low
    @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check_eq("rst_lfsr_en",   32'(lfsr_en),       32'd0);
    check_eq("rst_lfsr_clr",  32'(lfsr_clr),      32'd1);
    check_eq("rst_frm_err",   32'(frm_err),       32'd0);
    check_eq("rst_fb_sym",    32'(fb_sym),        32'd0);
    check_eq("rst_state",     32'(dut.state_q),   32'(IDLE));
    mon_en   = 1'b1;
    rdy_mode = 0;
    @(posedge clk); @(posedge clk); #1;

    // 1: counting message 0x01..0xEF
    base = frm_err_cnt;
    for (int i = 0; i < K; i++) msg[i] = 8'(i + 1);
    push_codeword(K);
    send_syms(K, 1'b1);
    wait_drain();
    check_eq("s1_frm_err_cnt", 32'(frm_err_cnt - base), 32'd0);

    // 2: stray non-sop symbol in IDLE, then all-zero message
    bus.in_valid = 1'b1; bus.in_sop = 1'b0; bus.in_data = 8'h55;
    @(negedge clk);
    check_eq("stray_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("stray_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    @(negedge clk);
    check_eq("stray_frm_err",   32'(frm_err),  32'd1);
    check_eq("idle_clr_before", 32'(lfsr_clr), 32'd1);
    @(negedge clk);
    check_eq("stray_frm_err_end", 32'(frm_err), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    push_codeword(K);
    send_syms(K, 1'b1);
    wait_drain();
    @(negedge clk);
    check_eq("idle_clr_after",  32'(lfsr_clr),      32'd1);
    check_eq("idle_valid_after", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;

    // 3: out_ready toggling, same message as scenario 1
    rdy_mode = 1;
    for (int i = 0; i < K; i++) msg[i] = 8'(i + 1);
    push_codeword(K);
    send_syms(K, 1'b1);
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk); #1;

    // 4: sop at message symbol 100 restarts the frame
    base = frm_err_cnt;
    push_prefix(100);
    send_syms(100, 1'b1);
    for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
    push_codeword(K);
    send_syms(K, 1'b1);
    wait_drain();
    check_eq("s4_frm_err_cnt", 32'(frm_err_cnt - base), 32'd1);

    // 5: reset during parity index 5, then a clean frame
    for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
    push_codeword(K);
    send_syms(K, 1'b1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_eq("s5_state",     32'(dut.state_q),   32'(IDLE));
    check_eq("s5_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("s5_lfsr_clr",  32'(lfsr_clr),      32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
    push_codeword(K);
    send_syms(K, 1'b1);
    wait_drain();

`ifdef RS_ENC_SHORTEN_EN
    // 6: shortened code, then cfg_k=0 falls back to K
    cfg_k = 8'd10;
    for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
    push_codeword(10);
    send_syms(10, 1'b1);
    wait_drain();
    cfg_k = 8'd0;
    for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
    push_codeword(K);
    send_syms(K, 1'b1);
    wait_drain();
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
